// File: rtl/sync_pulse_pkg.sv
// Shared limits and types for the sync_pulse_det synchronizer / edge detector.
// Latency: n/a (declarations only). Backpressure: n/a.
package sync_pulse_pkg;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MAX  = 15;

    typedef logic [3:0] filt_cnt_t;
endpackage

// File: rtl/sync_ff_chain.sv
// Plain resettable flop chain used as a metastability synchronizer.
// Latency: SYNC_STAGES cycles. Backpressure: none, it samples every cycle.
module sync_ff_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;

    // Pure shift: nothing may sit between stages, or the settling margin is lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/sync_pulse_det.sv
// Synchronizes pulse_a_in, registers its level and pulses pose_b_out on each rise.
// Latency: SYNC_STAGES+1 edges (+FILTER_LEN-1 with SYNC_PULSE_FILTER_EN). Backpressure: none.
module sync_pulse_det
    import sync_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_a_in,
    output logic pose_b_out,
    output logic level_b_out
);
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $fatal(1, "sync_pulse_det: SYNC_STAGES=%0d out of range", SYNC_STAGES);
    end
    if (FILTER_LEN < 2 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter
        $fatal(1, "sync_pulse_det: FILTER_LEN=%0d out of range", FILTER_LEN);
    end

    logic w_sync_s;
    logic w_level_nxt;
    logic r_level;
    logic r_pose;

    sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_chain (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (pulse_a_in),
        .o_q   (w_sync_s)
    );

`ifdef SYNC_PULSE_FILTER_EN
    localparam filt_cnt_t LP_CNT_LAST = filt_cnt_t'(FILTER_LEN - 1);

    filt_cnt_t r_cnt;
    logic      w_differ;

    assign w_differ = (w_sync_s != r_level);

    always_comb begin
        w_level_nxt = r_level;
        if (w_differ && (r_cnt == LP_CNT_LAST)) begin
            w_level_nxt = w_sync_s;
        end
    end

    // Counts how long the synchronized input has disagreed with the output level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_differ || (r_cnt == LP_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + filt_cnt_t'(1);
        end
    end
`else
    assign w_level_nxt = w_sync_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_pose  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_pose  <= w_level_nxt & ~r_level;
        end
    end

    assign level_b_out = r_level;
    assign pose_b_out  = r_pose;
endmodule

// File: tb/tb_sync_pulse_det.sv
// Bench for sync_pulse_det: vector table, corner sequences, random run vs delay-line model.
// Build with SYNC_PULSE_FILTER_EN to exercise the glitch filter sequences instead.
module tb_sync_pulse_det;
    localparam int S  = 2;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse_a_in = 1'b0;
    logic pose_b_out;
    logic level_b_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #13 clk = ~clk;

    sync_pulse_det #(.SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_a_in  (pulse_a_in),
        .pose_b_out  (pose_b_out),
        .level_b_out (level_b_out)
    );

    typedef struct {
        logic r;
        logic d;
        logic el;
        logic ep;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs mid-cycle, then look at the outputs just after the next rising edge.
    task automatic cyc(input logic r, input logic d, input logic el, input logic ep,
                       input string name);
        @(negedge clk);
        rst        = r;
        pulse_a_in = d;
        @(posedge clk);
        #1;
        check({name, ".level"}, level_b_out, el);
        check({name, ".pose"},  pose_b_out,  ep);
    endtask

    initial begin
        // Reset held with a noisy input: outputs must stay quiet.
        for (int i = 0; i < 349; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "reset_hold");
        end

`ifndef SYNC_PULSE_FILTER_EN
        // Edge k drives the input; outputs respond after edge k+2.
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0},   // single 1-cycle pulse
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0},   // two pulses split by a single low
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0},   // release with input already high
            '{1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0},   // reset mid-pulse
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].r, tbl[i].d, tbl[i].el, tbl[i].ep, $sformatf("table[%0d]", i));
        end

        // Hold high for 10 cycles: one pulse, level high 10 cycles, nothing on the fall.
        begin
            int n_pose;
            int n_high;
            n_pose = 0;
            n_high = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                rst        = 1'b0;
                pulse_a_in = (i < 10);
                @(posedge clk);
                #1;
                n_pose += int'(pose_b_out);
                n_high += int'(level_b_out);
                if (i == S) check("hold.first_pose", pose_b_out, 1'b1);
                if (i == 10 + S) check("hold.fall_level", level_b_out, 1'b0);
            end
            n_tests++;
            if (n_pose != 1) begin
                n_fail++;
                $display("FAIL hold.pose_count: got %0d, expected 1", n_pose);
            end
            n_tests++;
            if (n_high != 10) begin
                n_fail++;
                $display("FAIL hold.level_cycles: got %0d, expected 10", n_high);
            end
        end

        // Random levels with random gaps, against an ideal S-cycle delay line.
        begin
            logic hist [$];
            logic prev;
            logic d;
            int   hold;
            int   exp_rises;
            int   got_rises;
            int   bad_level;
            int   bad_pose;
            for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
            prev      = 1'b0;
            exp_rises = 0;
            got_rises = 0;
            bad_level = 0;
            bad_pose  = 0;
            for (int n = 0; n < 100 + 1; n++) begin
                d    = (n == 100) ? 1'b0 : 1'($urandom_range(0, 1));
                hold = (n == 100) ? S + 2 : 1 + int'($urandom_range(0, 254));
                for (int c = 0; c < hold; c++) begin
                    @(negedge clk);
                    rst        = 1'b0;
                    pulse_a_in = d;
                    @(posedge clk);
                    #1;
                    hist.push_front(d);
                    void'(hist.pop_back());
                    if (d && !prev) exp_rises++;
                    prev = d;
                    got_rises += int'(pose_b_out);
                    if (level_b_out !== hist[S]) bad_level++;
                    if (pose_b_out !== (hist[S] & ~hist[S+1])) bad_pose++;
                end
            end
            n_tests++;
            if (exp_rises != got_rises) begin
                n_fail++;
                $display("FAIL random.rise_count: got %0d, expected %0d", got_rises, exp_rises);
            end
            n_tests++;
            if (bad_level != 0) begin
                n_fail++;
                $display("FAIL random.level_delay: %0d cycles differ, expected 0", bad_level);
            end
            n_tests++;
            if (bad_pose != 0) begin
                n_fail++;
                $display("FAIL random.pose_timing: %0d cycles differ, expected 0", bad_pose);
            end
        end
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "filt.idle");
        // 2-cycle pulse is swallowed by the filter.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "filt2.c0");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "filt2.c1");
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("filt2.q%0d", i));
        // 3-cycle pulse passes: high after edge k+4 for 3 cycles.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "filt3.k0");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "filt3.k1");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "filt3.k2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "filt3.k3");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "filt3.k4");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "filt3.k5");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "filt3.k6");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "filt3.k7");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "filt3.k8");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
